// File: rtl/branch_predictor_bht.sv
// Bimodal branch predictor: 2-bit saturating counters indexed by PC, with a registered
// mispredict/redirect output and branch/mispredict event counters. Define BP_GSHARE_EN for gshare indexing.
module branch_predictor_bht #(
    parameter int         IDX_BITS = 6,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pred_pc,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_take,
    input  logic        upd_pred,
    input  logic [31:0] upd_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mispredict_count
);

    localparam int DEPTH = 1 << IDX_BITS;

    logic [1:0]          ctr [DEPTH];
    logic [IDX_BITS-1:0] pred_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic [1:0]          upd_cur;
    logic [1:0]          upd_next;
    logic                mp_now;
    logic                unused_pc_bits;

`ifdef BP_GSHARE_EN
    logic [IDX_BITS-1:0] ghr;

    // History is advanced from resolved outcomes only; training sees the pre-shift value.
    assign pred_idx = pred_pc[IDX_BITS+1:2] ^ ghr;
    assign upd_idx  = upd_pc[IDX_BITS+1:2] ^ ghr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (upd_valid) begin
            ghr <= {ghr[IDX_BITS-2:0], upd_take};
        end
    end
`else
    assign pred_idx = pred_pc[IDX_BITS+1:2];
    assign upd_idx  = upd_pc[IDX_BITS+1:2];
`endif

    assign unused_pc_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0]};

    // Same-index lookup during an update returns the stored (pre-update) value.
    assign pred_taken = ctr[pred_idx][1];

    always_comb begin
        upd_cur  = ctr[upd_idx];
        upd_next = upd_cur;
        if (upd_take) begin
            if (upd_cur != 2'b11) upd_next = upd_cur + 2'd1;
        end else begin
            if (upd_cur != 2'b00) upd_next = upd_cur - 2'd1;
        end
    end

    assign mp_now = upd_valid & (upd_take ^ upd_pred);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ctr[i] <= CNT_INIT;
        end else if (upd_valid) begin
            ctr[upd_idx] <= upd_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict       <= 1'b0;
            redirect_pc      <= '0;
            br_count         <= '0;
            mispredict_count <= '0;
        end else begin
            mispredict <= mp_now;
            if (mp_now) begin
                redirect_pc      <= upd_take ? upd_target : upd_pc + 32'd4;
                mispredict_count <= mispredict_count + 32'd1;
            end
            if (upd_valid) br_count <= br_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboarded bench for branch_predictor_bht (default bimodal build, IDX_BITS=6).
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_take;
    logic        upd_pred;
    logic [31:0] upd_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mispredict_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_br = 0;
    int exp_mp = 0;
    logic        pred_q[$];
    logic [31:0] mp_q[$];

    branch_predictor_bht dut (
        .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_take(upd_take), .upd_pred(upd_pred),
        .upd_target(upd_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .br_count(br_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; expected pred_taken is for this cycle, expected redirect for the next.
    task automatic vec(input logic [31:0] pp, input logic v, input logic [31:0] pc,
                       input logic tk, input logic pr, input logic [31:0] tgt,
                       input logic e_pred, input logic e_mp, input logic [31:0] e_redir);
        @(posedge clk);
        #1;
        pred_pc    = pp;
        upd_valid  = v;
        upd_pc     = pc;
        upd_take   = tk;
        upd_pred   = pr;
        upd_target = tgt;
        pred_q.push_back(e_pred);
        if (e_mp) begin
            mp_q.push_back(e_redir);
            exp_mp++;
        end
        if (v) exp_br++;
    endtask

    // Monitor: pops expectations whenever the DUT presents a lookup or a mispredict pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pred_q.size() > 0) check("pred_taken", {31'd0, pred_taken}, {31'd0, pred_q.pop_front()});
            if (mispredict) begin
                if (mp_q.size() == 0) check("unexpected_mispredict", 32'd1, 32'd0);
                else                  check("redirect_pc", redirect_pc, mp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        pred_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0;
        upd_take = 1'b0; upd_pred = 1'b0; upd_target = '0;
        #12;
        check("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("reset_mispredict", {31'd0, mispredict}, 32'd0);
        check("reset_redirect", redirect_pc, 32'd0);
        check("reset_br_count", br_count, 32'd0);
        check("reset_mp_count", mispredict_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Training up from weakly not-taken, idx 0
        vec(32'h100, 1, 32'h100, 1, 0, 32'h2000, 0, 1, 32'h2000);
        vec(32'h100, 1, 32'h100, 1, 0, 32'h2004, 1, 1, 32'h2004);
        // Saturate at 11, then one not-taken -> 10
        for (int i = 0; i < 4; i++) vec(32'h100, 1, 32'h100, 1, 1, 32'h3000, 1, 0, 32'h0);
        vec(32'h100, 1, 32'h100, 0, 1, 32'h3000, 1, 1, 32'h104);
        vec(32'h100, 0, 32'h100, 0, 0, 32'h0, 1, 0, 32'h0);
        // Walk down to 00 and hold
        vec(32'h100, 1, 32'h100, 0, 0, 32'h0, 1, 0, 32'h0);
        vec(32'h100, 1, 32'h100, 0, 0, 32'h0, 0, 0, 32'h0);
        vec(32'h100, 1, 32'h100, 0, 0, 32'h0, 0, 0, 32'h0);
        vec(32'h100, 1, 32'h100, 0, 0, 32'h0, 0, 0, 32'h0);
        vec(32'h100, 0, 32'h100, 0, 0, 32'h0, 0, 0, 32'h0);
        // Fall-through redirects, including 32-bit wrap; back-to-back pulses
        vec(32'h1FC, 1, 32'h1FC, 0, 1, 32'h5555, 0, 1, 32'h200);
        vec(32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 1, 32'h1234, 0, 1, 32'h0);
        vec(32'h1FC, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        vec(32'h1FC, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        check("redirect_hold", redirect_pc, 32'h0);
        // Collision: old value this cycle, new value next cycle via alias 0x140
        vec(32'h40, 1, 32'h40, 1, 0, 32'h800, 0, 1, 32'h800);
        vec(32'h140, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0);
        vec(32'h44, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        check("redirect_after_collision", redirect_pc, 32'h800);
        check("br_count", br_count, exp_br);
        check("mp_count", mispredict_count, exp_mp);
        check("br_count_hand", br_count, 32'd14);
        check("mp_count_hand", mispredict_count, 32'd6);
        check("pending_mispredicts", mp_q.size(), 32'd0);

        // Reset mid-update: the in-flight mispredicting update must vanish
        @(posedge clk);
        #1;
        pred_pc = 32'h40; upd_valid = 1'b1; upd_pc = 32'h40;
        upd_take = 1'b1; upd_pred = 1'b0; upd_target = 32'h9999;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("midrst_br_count", br_count, 32'd0);
        check("midrst_mp_count", mispredict_count, 32'd0);
        check("midrst_mispredict", {31'd0, mispredict}, 32'd0);
        check("midrst_redirect", redirect_pc, 32'd0);
        @(negedge clk);
        upd_valid = 1'b0;
        rst_n = 1'b1;
        pred_pc = 32'h100;
        #1;
        check("postrst_pred_idx0", {31'd0, pred_taken}, 32'd0);
        @(posedge clk);
        #1;
        check("postrst_mispredict", {31'd0, mispredict}, 32'd0);
        check("postrst_br_count", br_count, 32'd0);
        pred_pc = 32'h40;
        #1;
        check("postrst_pred_idx16", {31'd0, pred_taken}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("final_pending", mp_q.size() + pred_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
